// File: rtl/freq_pkg.sv
// Shared types and constants for the gated frequency counter.
package freq_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic {
        COUNT = 1'b0,
        LATCH = 1'b1
    } state_t;

    localparam bcd_digit_t BCD_MAX             = 4'd9;
    localparam int         DEFAULT_GATE_CYCLES = 100000000;
    localparam int         NUM_DIGITS          = 4;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD decade: counts 0-9 on inc, carry is combinational so a chain ripples in one cycle.
module bcd_digit_counter
    import freq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output bcd_digit_t digit,
    output logic       carry
);

    assign carry = inc && (digit == BCD_MAX);

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (inc) begin
            digit <= carry ? '0 : digit + 4'd1;
        end
    end

endmodule

// File: rtl/freq_gate_counter.sv
// Counts Infreq rising edges over a GATE_CYCLES window and publishes a saturating BCD result.
// Optional macro FREQ_HOLD_EN adds a hold input that freezes the published result.
module freq_gate_counter
    import freq_pkg::*;
#(
    parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES,
    parameter int SYNC_STAGES = 2,
    parameter int DIGITS      = NUM_DIGITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Infreq,
`ifdef FREQ_HOLD_EN
    input  logic                hold,
`endif
    output logic [4*DIGITS-1:0] bcd,
    output logic                ovf,
    output logic                valid
);

    localparam int               CNT_W     = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_d;
    logic                   rise;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_ff <= '0;
            sync_d  <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], Infreq};
            sync_d  <= sync_ff[SYNC_STAGES-1];
        end
    end

    assign rise = sync_ff[SYNC_STAGES-1] && !sync_d;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] gate_cnt;
    logic             gate_done;
    logic             counting;
    logic             latching;
    logic             publish;

    assign gate_done = (gate_cnt == GATE_LAST);
    assign counting  = (state == COUNT);
    assign latching  = (state == LATCH);

`ifdef FREQ_HOLD_EN
    assign publish = latching && !hold;
`else
    assign publish = latching;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= COUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            COUNT:   if (gate_done) state_nxt = LATCH;
            LATCH:   state_nxt = COUNT;
            default: state_nxt = COUNT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gate_cnt <= '0;
        end else if (latching) begin
            gate_cnt <= '0;
        end else begin
            gate_cnt <= gate_cnt + CNT_W'(1);
        end
    end

    bcd_digit_t          work [DIGITS];
    logic [DIGITS-1:0]   dig_inc;
    logic [DIGITS-1:0]   dig_carry;
    logic [DIGITS-1:0]   dig_max;
    logic [4*DIGITS-1:0] work_bcd;
    logic                all_max;
    logic                count_rise;
    logic                sat_hit;
    logic                ovf_w;

    assign count_rise = counting && rise;
    assign all_max    = &dig_max;

    // The LATCH cycle clears every decade, which is also where a rise is dropped.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_counter u_digit (
            .clk   (clk),
            .reset (reset),
            .clr   (latching),
            .inc   (dig_inc[i]),
            .digit (work[i]),
            .carry (dig_carry[i])
        );

        assign dig_max[i]         = (work[i] == BCD_MAX);
        assign work_bcd[4*i +: 4] = work[i];

        if (i == 0) begin : g_lsd
            assign dig_inc[i] = count_rise && !all_max;
        end else begin : g_upper
            assign dig_inc[i] = dig_carry[i-1];
        end
    end

    // Saturation is normally caught before the chain; a carry out of the top decade means the same.
    assign sat_hit = (count_rise && all_max) || dig_carry[DIGITS-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_w <= 1'b0;
        end else if (latching) begin
            ovf_w <= 1'b0;
        end else if (sat_hit) begin
            ovf_w <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcd   <= '0;
            ovf   <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= publish;
            if (publish) begin
                bcd <= work_bcd;
                ovf <= ovf_w;
            end
        end
    end

endmodule

// File: tb/tb_freq_gate_counter.sv
// Self-checking bench: three DUTs with different gate windows share Infreq and reset.
module tb_freq_gate_counter;

    localparam int SYNC      = 2;
    localparam int G_A       = 40;
    localparam int G_B       = 2500;
    localparam int G_C       = 25000;
    localparam int MAX_EDGES = 60000;

    typedef enum int {M_LOW, M_HIGH, M_TOGGLE, M_RAND} mode_t;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic Infreq = 1'b0;
`ifdef FREQ_HOLD_EN
    logic hold   = 1'b0;
`endif

    logic [15:0] bcd_a, bcd_b, bcd_c;
    logic        ovf_a, ovf_b, ovf_c;
    logic        valid_a, valid_b, valid_c;

    int    n_tests  = 0;
    int    n_fail   = 0;
    int    edge_idx = 0;
    bit    samp [0:MAX_EDGES];
    mode_t mode     = M_LOW;
    int    half     = 1;
    int    ph       = 0;

    freq_gate_counter #(.GATE_CYCLES(G_A), .SYNC_STAGES(SYNC)) u_dut_a (
        .clk(clk), .reset(reset), .Infreq(Infreq),
`ifdef FREQ_HOLD_EN
        .hold(hold),
`endif
        .bcd(bcd_a), .ovf(ovf_a), .valid(valid_a)
    );

    freq_gate_counter #(.GATE_CYCLES(G_B), .SYNC_STAGES(SYNC)) u_dut_b (
        .clk(clk), .reset(reset), .Infreq(Infreq),
`ifdef FREQ_HOLD_EN
        .hold(hold),
`endif
        .bcd(bcd_b), .ovf(ovf_b), .valid(valid_b)
    );

    freq_gate_counter #(.GATE_CYCLES(G_C), .SYNC_STAGES(SYNC)) u_dut_c (
        .clk(clk), .reset(reset), .Infreq(Infreq),
`ifdef FREQ_HOLD_EN
        .hold(hold),
`endif
        .bcd(bcd_c), .ovf(ovf_c), .valid(valid_c)
    );

    always #5 clk = ~clk;

    // Infreq is driven on the falling edge so every rising edge samples a settled value.
    always @(negedge clk) begin
        case (mode)
            M_LOW:    Infreq = 1'b0;
            M_HIGH:   Infreq = 1'b1;
            M_TOGGLE: begin
                ph = ph + 1;
                if (ph >= half) begin
                    ph     = 0;
                    Infreq = ~Infreq;
                end
            end
            default:  Infreq = 1'($urandom_range(0, 1));
        endcase
    end

    // Record the Infreq level seen at each rising edge since the last reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_idx = 0;
        end else begin
            edge_idx = edge_idx + 1;
            if (edge_idx <= MAX_EDGES) samp[edge_idx] = Infreq;
        end
    end

    function automatic bit s_at(input int j);
        return (j < 1 || j > MAX_EDGES) ? 1'b0 : samp[j];
    endfunction

    // Rising edges counted by the window whose result is published at edge k.
    function automatic int model_count(input int g, input int k);
        int c = 0;
        for (int e = k - g; e <= k - 1; e++) begin
            if (s_at(e - SYNC) && !s_at(e - SYNC - 1)) c++;
        end
        return c;
    endfunction

    // {ovf, bcd} for a raw edge count: saturate at 9999, flag anything above.
    function automatic logic [16:0] model_out(input int cnt);
        int v = (cnt > 9999) ? 9999 : cnt;
        return {cnt > 9999, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic wait_valid(input int sel, input int budget, output bit got,
                              output logic [16:0] res, output int at);
        got = 1'b0;
        res = '0;
        at  = 0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            case (sel)
                0: if (valid_a === 1'b1) begin got = 1'b1; res = {ovf_a, bcd_a}; end
                1: if (valid_b === 1'b1) begin got = 1'b1; res = {ovf_b, bcd_b}; end
                default: if (valid_c === 1'b1) begin got = 1'b1; res = {ovf_c, bcd_c}; end
            endcase
            if (got) begin
                at = edge_idx;
                return;
            end
        end
    endtask

    task automatic set_mode(input mode_t m, input int h);
        @(posedge clk);
        #1;
        mode = m;
        half = h;
        ph   = 0;
    endtask

    // Pulses reset for three cycles; returns just after release, before the first counted edge.
    task automatic pulse_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        mode  = M_LOW;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({valid_a, ovf_a, bcd_a} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_a: got %h want 0", {valid_a, ovf_a, bcd_a});
        end
        n_tests++;
        if ({valid_b, ovf_b, bcd_b} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_b: got %h want 0", {valid_b, ovf_b, bcd_b});
        end
        n_tests++;
        if ({valid_c, ovf_c, bcd_c} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_c: got %h want 0", {valid_c, ovf_c, bcd_c});
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_period4();
        bit got;
        logic [16:0] res;
        int at0, at1;
        set_mode(M_TOGGLE, 2);
        wait_valid(0, 100, got, res, at0);
        n_tests++;
        if (!got || at0 != G_A + 1) begin
            n_fail++;
            $display("FAIL p4_first_valid: got=%0d edge=%0d want edge %0d", got, at0, G_A + 1);
        end
        wait_valid(0, 60, got, res, at1);
        n_tests++;
        if (!got || at1 - at0 != G_A + 1) begin
            n_fail++;
            $display("FAIL p4_period: got=%0d spacing=%0d want %0d", got, at1 - at0, G_A + 1);
        end
        n_tests++;
        if (res !== 17'h00010) begin
            n_fail++;
            $display("FAIL p4_value: got %h want 00010", res);
        end
    endtask

    task automatic test_static_high();
        bit got;
        logic [16:0] res;
        int at;
        set_mode(M_HIGH, 1);
        for (int w = 0; w < 3; w++) begin
            wait_valid(0, 60, got, res, at);
            n_tests++;
            if (!got || (w > 0 && res !== 17'h0)) begin
                n_fail++;
                $display("FAIL static_high w%0d: got=%0d value %h want 00000", w, got, res);
            end
        end
    endtask

    task automatic test_random();
        bit got;
        logic [16:0] res;
        int at, prev;
        set_mode(M_RAND, 1);
        wait_valid(0, 60, got, res, prev);
        for (int w = 0; w < 6; w++) begin
            wait_valid(0, 60, got, res, at);
            n_tests++;
            if (!got || at - prev != G_A + 1) begin
                n_fail++;
                $display("FAIL rand_period w%0d: got=%0d spacing=%0d want %0d", w, got, at - prev, G_A + 1);
            end
            n_tests++;
            if (res !== model_out(model_count(G_A, at))) begin
                n_fail++;
                $display("FAIL rand_value w%0d: got %h want %h", w, res, model_out(model_count(G_A, at)));
            end
            prev = at;
        end
    endtask

    task automatic test_reset_mid_window();
        bit got;
        logic [16:0] res;
        int at;
        set_mode(M_TOGGLE, 2);
        wait_valid(0, 60, got, res, at);
        repeat (15) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_tests++;
        if ({valid_a, ovf_a, bcd_a} !== 18'h0) begin
            n_fail++;
            $display("FAIL midreset_immediate: got %h want 0", {valid_a, ovf_a, bcd_a});
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        mode  = M_RAND;
        wait_valid(0, 60, got, res, at);
        n_tests++;
        if (!got || at != G_A + 1) begin
            n_fail++;
            $display("FAIL midreset_timing: got=%0d edge=%0d want %0d", got, at, G_A + 1);
        end
        n_tests++;
        if (res !== model_out(model_count(G_A, at))) begin
            n_fail++;
            $display("FAIL midreset_value: got %h want %h", res, model_out(model_count(G_A, at)));
        end
    endtask

    task automatic test_carry();
        bit got;
        logic [16:0] res;
        int at;
        pulse_reset();
        mode = M_TOGGLE;
        half = 1;
        ph   = 0;
        repeat (2000) @(negedge clk);
        @(posedge clk);
        #1;
        mode = M_LOW;
        wait_valid(1, 700, got, res, at);
        n_tests++;
        if (!got || at != G_B + 1) begin
            n_fail++;
            $display("FAIL carry_timing: got=%0d edge=%0d want %0d", got, at, G_B + 1);
        end
        n_tests++;
        if (res !== 17'h01000) begin
            n_fail++;
            $display("FAIL carry_value: got %h want 01000", res);
        end
        n_tests++;
        if (res !== model_out(model_count(G_B, at))) begin
            n_fail++;
            $display("FAIL carry_model: got %h want %h", res, model_out(model_count(G_B, at)));
        end
    endtask

    task automatic test_saturate();
        bit got;
        logic [16:0] res;
        int at;
        pulse_reset();
        mode = M_TOGGLE;
        half = 1;
        ph   = 0;
        repeat (24000) @(negedge clk);
        @(posedge clk);
        #1;
        mode = M_LOW;
        wait_valid(2, 2000, got, res, at);
        n_tests++;
        if (!got || res !== 17'h19999) begin
            n_fail++;
            $display("FAIL sat_value: got=%0d value %h want 19999", got, res);
        end
        n_tests++;
        if (res !== model_out(model_count(G_C, at))) begin
            n_fail++;
            $display("FAIL sat_model: got %h want %h", res, model_out(model_count(G_C, at)));
        end
        wait_valid(2, G_C + 100, got, res, at);
        n_tests++;
        if (!got || at != 2 * (G_C + 1) || res !== 17'h0) begin
            n_fail++;
            $display("FAIL sat_clear: got=%0d edge=%0d value %h want edge %0d value 00000",
                     got, at, res, 2 * (G_C + 1));
        end
    endtask

`ifdef FREQ_HOLD_EN
    task automatic test_hold();
        bit got;
        logic [16:0] res;
        int at0, at;
        pulse_reset();
        mode = M_TOGGLE;
        half = 2;
        ph   = 0;
        wait_valid(0, 60, got, res, at0);
        wait_valid(0, 60, got, res, at0);
        @(posedge clk);
        #1;
        hold = 1'b1;
        mode = M_TOGGLE;
        half = 1;
        ph   = 0;
        wait_valid(0, 44, got, res, at);
        n_tests++;
        if (got) begin
            n_fail++;
            $display("FAIL hold_no_valid: valid seen at edge %0d while held", at);
        end
        n_tests++;
        if ({ovf_a, bcd_a} !== 17'h00010) begin
            n_fail++;
            $display("FAIL hold_frozen: got %h want 00010", {ovf_a, bcd_a});
        end
        @(posedge clk);
        #1;
        hold = 1'b0;
        wait_valid(0, 60, got, res, at);
        n_tests++;
        if (!got || at - at0 != 2 * (G_A + 1) || res !== 17'h00020) begin
            n_fail++;
            $display("FAIL hold_release: got=%0d spacing=%0d value %h want %0d 00020",
                     got, at - at0, res, 2 * (G_A + 1));
        end
    endtask
`endif

    initial begin
        test_reset();
        test_period4();
        test_static_high();
        test_random();
        test_reset_mid_window();
        test_carry();
        test_saturate();
`ifdef FREQ_HOLD_EN
        test_hold();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
